// File: rtl/byte_loader_if.sv
// byte_loader_if: request/result and SRAM byte-read signals of byte_loader.
// slave is the loader side; master is the requester plus SRAM side.
interface byte_loader_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        size;
   logic              uns;
   logic              busy;
   logic              done;
   logic              fault;
   logic [31:0]       data;
   logic              sram_re;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_ready;
   logic [7:0]        sram_rdata;

   modport slave (
      input  req, addr, size, uns, sram_ready, sram_rdata,
      output busy, done, fault, data, sram_re, sram_addr
   );

   modport master (
      output req, addr, size, uns, sram_ready, sram_rdata,
      input  busy, done, fault, data, sram_re, sram_addr
   );
endinterface

// File: rtl/byte_loader.sv
// byte_loader: byte-serial SRAM load unit with sign/zero extension.
// Define BYTE_LOADER_MISALIGN_TRAP_EN to fault misaligned half/word loads.
module byte_loader #(
   parameter int ADDR_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   byte_loader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, FINISH} state_t;

   state_t      state;
   logic [1:0]  i;
   logic [1:0]  n_last;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] buf_q;
   logic [31:0] merged;
   logic [31:0] ext;
   logic        bad;

   always_comb begin
      bad = (bus.size == 2'b11);
`ifdef BYTE_LOADER_MISALIGN_TRAP_EN
      if (bus.size == 2'b01 && bus.addr[0])
         bad = 1'b1;
      if (bus.size == 2'b10 && bus.addr[1:0] != 2'b00)
         bad = 1'b1;
`endif
   end

   // Incoming byte dropped into lane i, little-endian.
   always_comb begin
      merged = buf_q;
      merged[{i, 3'b000} +: 8] = bus.sram_rdata;
   end

   always_comb begin
      unique case (1'b1)
         size_q == 2'b00:
            ext = {{24{~uns_q & merged[7]}}, merged[7:0]};
         size_q == 2'b01:
            ext = {{16{~uns_q & merged[15]}}, merged[15:0]};
         default:
            ext = merged;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.fault     <= 1'b0;
         bus.data      <= '0;
         bus.sram_re   <= 1'b0;
         bus.sram_addr <= '0;
         i             <= '0;
         n_last        <= '0;
         size_q        <= '0;
         uns_q         <= 1'b0;
         buf_q         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               bus.done  <= 1'b0;
               bus.fault <= 1'b0;
               if (bus.req) begin
                  bus.busy <= 1'b1;
                  if (bad) begin
                     state     <= FINISH;
                     bus.done  <= 1'b1;
                     bus.fault <= 1'b1;
                  end else begin
                     state         <= FETCH;
                     bus.sram_re   <= 1'b1;
                     bus.sram_addr <= bus.addr;
                     i             <= '0;
                     buf_q         <= '0;
                     size_q        <= bus.size;
                     uns_q         <= bus.uns;
                     n_last        <= (bus.size == 2'b00) ? 2'd0 :
                                      (bus.size == 2'b01) ? 2'd1 : 2'd3;
                  end
               end
            end
            FETCH: begin
               if (bus.sram_ready) begin
                  buf_q         <= merged;
                  i             <= i + 2'd1;
                  bus.sram_addr <= bus.sram_addr + ADDR_W'(1);
                  if (i == n_last) begin
                     state       <= FINISH;
                     bus.sram_re <= 1'b0;
                     bus.done    <= 1'b1;
                     bus.data    <= ext;
                  end
               end
            end
            FINISH: begin
               state     <= IDLE;
               bus.busy  <= 1'b0;
               bus.done  <= 1'b0;
               bus.fault <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_byte_loader.sv
// tb_byte_loader: scoreboard bench for byte_loader with a 16-byte SRAM model.
// SRAM is indexed by sram_addr[3:0]; tests preload the bytes they need.
module tb_byte_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   byte_loader_if #(.ADDR_W(32)) bus();

   byte_loader #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [16];
   assign bus.sram_rdata = mem[bus.sram_addr[3:0]];

   typedef struct packed {
      logic [31:0] data;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] trace[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_data;
   int          lat;
   logic        got;
   logic [31:0] odata;
   logic        ofault;

   // Issues one request and waits (bounded) for done, tracing FETCH addresses.
   task automatic run_load(input logic [31:0] a, input logic [1:0] sz,
                           input logic u, input int waits);
      int wc = 0;
      trace.delete();
      got = 1'b0;
      @(negedge clk);
      bus.req = 1'b1; bus.addr = a; bus.size = sz; bus.uns = u;
      bus.sram_ready = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      lat = 1;
      repeat (100) begin
         if (bus.done) begin
            got = 1'b1; odata = bus.data; ofault = bus.fault;
            break;
         end
         if (bus.sram_re) trace.push_back(bus.sram_addr);
         if (bus.sram_re && wc < waits) begin
            bus.sram_ready = 1'b0; wc++;
         end else begin
            bus.sram_ready = 1'b1; wc = 0;
         end
         @(negedge clk);
         lat++;
      end
      bus.sram_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.done); end
      n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %b want 0", bus.fault); end
      n_cmp++; if (bus.data !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", bus.data); end
      n_cmp++; if (bus.sram_re !== 1'b0) begin n_bad++; $display("FAIL rst_re got %b want 0", bus.sram_re); end
      n_cmp++; if (bus.sram_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus.sram_addr); end
      rst = 1'b0;
      last_data = 32'h0;
   endtask

   task automatic test_word();
      exp_t e;
      mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
      exp_q.push_back('{data: 32'h12345678, fault: 1'b0});
      last_data = 32'h12345678;
      run_load(32'h100, 2'b10, 1'b0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL word_timeout got no done want done"); end
      else begin
         if (odata !== e.data) begin n_bad++; $display("FAIL word_data got %h want %h", odata, e.data); end
         n_cmp++; if (ofault !== e.fault) begin n_bad++; $display("FAIL word_fault got %b want %b", ofault, e.fault); end
         n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL word_latency got %0d want 5", lat); end
      end
      n_cmp++;
      if (trace.size() != 4) begin n_bad++; $display("FAIL word_trace_len got %0d want 4", trace.size()); end
      else
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (trace[k] !== 32'h100 + k) begin
               n_bad++; $display("FAIL word_addr%0d got %h want %h", k, trace[k], 32'h100 + k);
            end
         end
   endtask

   task automatic test_reserved();
      exp_t e;
      exp_q.push_back('{data: last_data, fault: 1'b1});
      run_load(32'h0, 2'b11, 1'b0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL rsvd_timeout got no done want done"); end
      else begin
         if (ofault !== e.fault) begin n_bad++; $display("FAIL rsvd_fault got %b want %b", ofault, e.fault); end
         n_cmp++; if (odata !== e.data) begin n_bad++; $display("FAIL rsvd_data got %h want %h", odata, e.data); end
         n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rsvd_latency got %0d want 1", lat); end
      end
      n_cmp++; if (trace.size() != 0) begin n_bad++; $display("FAIL rsvd_sram got %0d reads want 0", trace.size()); end
   endtask

   task automatic test_byte_sign();
      exp_t e;
      mem[7] = 8'h80;
      for (int u = 0; u < 2; u++) begin
         e.data  = (u == 0) ? 32'hFFFFFF80 : 32'h00000080;
         e.fault = 1'b0;
         exp_q.push_back(e);
         last_data = e.data;
         run_load(32'h7, 2'b00, u[0], 0);
         e = exp_q.pop_front();
         n_cmp++;
         if (!got) begin n_bad++; $display("FAIL byte_u%0d_timeout got no done want done", u); end
         else begin
            if (odata !== e.data) begin n_bad++; $display("FAIL byte_u%0d_data got %h want %h", u, odata, e.data); end
            n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL byte_u%0d_latency got %0d want 2", u, lat); end
         end
      end
   endtask

   task automatic test_half_wait();
      exp_t e;
      mem[2] = 8'h34; mem[3] = 8'hF2;
      exp_q.push_back('{data: 32'hFFFFF234, fault: 1'b0});
      last_data = 32'hFFFFF234;
      run_load(32'h2, 2'b01, 1'b0, 3);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL half_timeout got no done want done"); end
      else begin
         if (odata !== e.data) begin n_bad++; $display("FAIL half_data got %h want %h", odata, e.data); end
         n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL half_latency got %0d want 9", lat); end
      end
      n_cmp++;
      if (trace.size() != 8) begin n_bad++; $display("FAIL half_trace_len got %0d want 8", trace.size()); end
      else
         for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (trace[k] !== 32'h2 + k / 4) begin
               n_bad++; $display("FAIL half_addr%0d got %h want %h", k, trace[k], 32'h2 + k / 4);
            end
         end
   endtask

   task automatic test_misalign();
      exp_t e;
      int   want_lat;
      int   want_n;
      mem[2] = 8'h11; mem[3] = 8'h22; mem[4] = 8'h33; mem[5] = 8'h44;
`ifdef BYTE_LOADER_MISALIGN_TRAP_EN
      e = '{data: last_data, fault: 1'b1};
      want_lat = 1; want_n = 0;
`else
      e = '{data: 32'h44332211, fault: 1'b0};
      want_lat = 5; want_n = 4;
`endif
      exp_q.push_back(e);
      last_data = e.data;
      run_load(32'h2, 2'b10, 1'b0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL mis_timeout got no done want done"); end
      else begin
         if (odata !== e.data) begin n_bad++; $display("FAIL mis_data got %h want %h", odata, e.data); end
         n_cmp++; if (ofault !== e.fault) begin n_bad++; $display("FAIL mis_fault got %b want %b", ofault, e.fault); end
         n_cmp++; if (lat != want_lat) begin n_bad++; $display("FAIL mis_latency got %0d want %0d", lat, want_lat); end
      end
      n_cmp++;
      if (trace.size() != want_n) begin n_bad++; $display("FAIL mis_reads got %0d want %0d", trace.size(), want_n); end
      else
         for (int k = 0; k < want_n; k++) begin
            n_cmp++;
            if (trace[k] !== 32'h2 + k) begin
               n_bad++; $display("FAIL mis_addr%0d got %h want %h", k, trace[k], 32'h2 + k);
            end
         end
   endtask

   task automatic test_wrap();
      exp_t        e;
      logic [31:0] wa [4];
      int          want_n;
      wa[0] = 32'hFFFFFFFE; wa[1] = 32'hFFFFFFFF;
      wa[2] = 32'h00000000; wa[3] = 32'h00000001;
      mem[14] = 8'hA1; mem[15] = 8'hB2; mem[0] = 8'hC3; mem[1] = 8'hD4;
`ifdef BYTE_LOADER_MISALIGN_TRAP_EN
      e = '{data: last_data, fault: 1'b1};
      want_n = 0;
`else
      e = '{data: 32'hD4C3B2A1, fault: 1'b0};
      want_n = 4;
`endif
      exp_q.push_back(e);
      last_data = e.data;
      run_load(32'hFFFFFFFE, 2'b10, 1'b0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL wrap_timeout got no done want done"); end
      else begin
         if (odata !== e.data) begin n_bad++; $display("FAIL wrap_data got %h want %h", odata, e.data); end
      end
      n_cmp++;
      if (trace.size() != want_n) begin n_bad++; $display("FAIL wrap_reads got %0d want %0d", trace.size(), want_n); end
      else
         for (int k = 0; k < want_n; k++) begin
            n_cmp++;
            if (trace[k] !== wa[k]) begin
               n_bad++; $display("FAIL wrap_addr%0d got %h want %h", k, trace[k], wa[k]);
            end
         end
   endtask

   task automatic test_reset_abort();
      exp_t e;
      int   dones = 0;
      mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
      @(negedge clk);
      bus.req = 1'b1; bus.addr = 32'h100; bus.size = 2'b10; bus.uns = 1'b0;
      bus.sram_ready = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_data = 32'h0;
      n_cmp++; if (bus.sram_re !== 1'b0) begin n_bad++; $display("FAIL abort_re got %b want 0", bus.sram_re); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", bus.busy); end
      repeat (8) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_done got %0d dones want 0", dones); end
      mem[7] = 8'h80;
      exp_q.push_back('{data: 32'hFFFFFF80, fault: 1'b0});
      last_data = 32'hFFFFFF80;
      run_load(32'h7, 2'b00, 1'b0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL abort_next_timeout got no done want done"); end
      else if (odata !== e.data) begin
         n_bad++; $display("FAIL abort_next_data got %h want %h", odata, e.data);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   t_done = -1;
      int   dones = 0;
      mem[4] = 8'h5A;
      @(negedge clk);
      bus.req = 1'b1; bus.addr = 32'h4; bus.size = 2'b00; bus.uns = 1'b1;
      bus.sram_ready = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (bus.done) begin
            dones++;
            if (t_done < 0) t_done = c;
         end
         if (c == 3) begin
            n_cmp++;
            if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got %b want 0", bus.busy); end
         end
         if (c == 4) begin
            n_cmp++;
            if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept_busy got %b want 1", bus.busy); end
         end
      end
      bus.req = 1'b0;
      n_cmp++; if (t_done != 2) begin n_bad++; $display("FAIL b2b_first_done got cycle %0d want 2", t_done); end
      n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL b2b_dones got %0d want 1", dones); end
      exp_q.push_back('{data: 32'h0000005A, fault: 1'b0});
      last_data = 32'h0000005A;
      got = 1'b0;
      repeat (20) begin
         if (bus.done) begin got = 1'b1; odata = bus.data; break; end
         @(negedge clk);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL b2b_second_timeout got no done want done"); end
      else if (odata !== e.data) begin
         n_bad++; $display("FAIL b2b_second_data got %h want %h", odata, e.data);
      end
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = 8'h00;
      bus.req = 1'b0; bus.addr = '0; bus.size = 2'b00; bus.uns = 1'b0;
      bus.sram_ready = 1'b1;
      last_data = 32'h0;
      test_reset();
      test_word();
      test_reserved();
      test_byte_sign();
      test_half_wait();
      test_misalign();
      test_wrap();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/byte_loader.md
BYTE_LOADER -- requirements
Module: byte_loader

Interface
REQ-001 Parameter ADDR_W, default 32: width of the request and SRAM byte address.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 req  in  1  load request; sampled only in IDLE.
REQ-005 addr  in  ADDR_W  byte address of the load; sampled with req.
REQ-006 size  in  2  load size: 00 = byte, 01 = half, 10 = word, 11 = reserved; sampled with req.
REQ-007 uns  in  1  1 = zero-extend, 0 = sign-extend; sampled with req.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse; data is valid.
REQ-010 fault  out  1  one-cycle pulse, coincident with done; the load was rejected.
REQ-011 data  out  32  load result; held until the next done.
REQ-012 sram_re  out  1  byte-read request to the byte-wide SRAM.
REQ-013 sram_addr  out  ADDR_W  byte address for sram_re.
REQ-014 sram_ready  in  1  SRAM accepts the read this cycle.
REQ-015 sram_rdata  in  8  read byte; valid in any cycle with sram_re && sram_ready.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and FINISH.
REQ-017 IDLE -> FETCH on req when the request is legal; base address, size, uns and byte count n (1/2/4) are latched and byte index i is cleared.
REQ-018 In FETCH, sram_re SHALL be 1 and sram_addr SHALL equal base + i, modulo 2^ADDR_W (wrap-around at the top of the address space).
REQ-019 On sram_re && sram_ready, sram_rdata SHALL be stored in byte lane i (little-endian) and i incremented.
REQ-020 If i == n-1 at that handshake, the FSM SHALL go to FINISH; otherwise it stays in FETCH.
REQ-021 When sram_ready is low, FETCH SHALL hold with sram_re, sram_addr and i stable (wait states allowed indefinitely).
REQ-022 In FINISH, done = 1 and data = the assembled bytes extended to 32 bits per latched uns; the FSM then returns to IDLE.
REQ-023 Sign extension SHALL copy bit 7 (byte) or bit 15 (half); zero extension fills with 0; a word load is passed through unchanged.
REQ-024 Latency with sram_ready held high: req accepted at cycle T gives done at T+n+1 (byte T+2, half T+3, word T+5).
REQ-025 size 11 SHALL go IDLE -> FINISH with fault = 1, no SRAM access, and data unchanged.
REQ-026 req while busy SHALL be ignored, with no queueing.
REQ-027 req in the same cycle as done SHALL be ignored; the earliest new acceptance is the cycle after FINISH.
REQ-028 Outside FETCH, sram_re SHALL be 0.

Reset
REQ-029 On rst: state = IDLE, busy = 0, done = 0, fault = 0, data = 0, sram_re = 0, sram_addr = 0, i = 0.
REQ-030 rst during FETCH or FINISH SHALL abort the load; no done is produced and sram_re is low from the next cycle.
REQ-031 rst SHALL take priority over req in the same cycle.

Configuration
REQ-032 Macro BYTE_LOADER_MISALIGN_TRAP_EN controls misaligned loads.
REQ-033 With the macro defined, these loads SHALL fault as in REQ-025: a half with addr[0] != 0, or a word with addr[1:0] != 0.
REQ-034 Without the macro, misaligned loads SHALL proceed byte-serially per REQ-017..REQ-023, with fault raised only for size 11.

Verification
REQ-035 Word load, addr 0x100, SRAM bytes 0x100..0x103 = 78 56 34 12, ready high -> sram_addr 0x100..0x103, done at T+5, data = 0x12345678, fault = 0.
REQ-036 Byte load, addr 0x7, byte 0x80, uns = 0 -> data 0xFFFFFF80; repeated with uns = 1 -> data 0x00000080.
REQ-037 Half load, addr 0x2, bytes 34 F2, sram_ready low for 3 cycles before each byte -> sram_addr held during waits, data 0xFFFFF234, done at T+9.
REQ-038 Word load, addr 0x2 -> with the macro: done and fault at T+1, no sram_re, data unchanged; without the macro: reads 0x2..0x5 and assembles the word.
REQ-039 Word load, addr 0xFFFFFFFE, macro off (ADDR_W = 32) -> sram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-040 Word load with rst asserted on the second byte handshake -> no done, sram_re = 0 the next cycle; a following byte load completes normally.
